// File: rtl/toggle_decoder.sv
// toggle_decoder
//   Receive side of a toggle-encoded (T flip-flop) link. The transmitter inverts
//   k_in once per event, starting from 0 after reset. This block synchronises
//   k_in, turns every detected level change into a one-cycle pulse, counts the
//   events with saturation, and tracks link liveness with a three-state FSM.
//
// Ports
//   clk       in   rising-edge system clock
//   rst       in   synchronous active-high reset
//   k_in      in   toggle-encoded level, asynchronous to clk
//   clr       in   synchronous clear of count/overflow/timer/state (sync chain kept)
//   pulse     out  one-cycle pulse per detected toggle
//   count     out  toggles since rst/clr, saturating at 2**CW-1
//   overflow  out  sticky, set by a toggle while count is saturated
//   active    out  FSM is in ACTIVE
//   timeout   out  FSM is in STALL
module toggle_decoder #(
  parameter int unsigned CW      = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          k_in,
  input  logic          clr,
  output logic          pulse,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          active,
  output logic          timeout
);

  localparam int unsigned     TW        = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   CountMax  = {CW{1'b1}};
  localparam logic [TW-1:0]   TimerLast = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StActive, StStall} state_e;

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          s3_q, s3_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [TW-1:0] timer_q, timer_d;
  state_e        state_q, state_d;
  logic          active_q, active_d;
  logic          timeout_q, timeout_d;
  logic          tog_det;

  always_comb begin
    // s1/s2 form the synchroniser; s3 is the previous synchronised level.
    tog_det    = s2_q ^ s3_q;
    s1_d       = k_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    pulse_d    = tog_det;
    count_d    = count_q;
    overflow_d = overflow_q;
    timer_d    = timer_q;
    state_d    = state_q;

    if (clr) begin
      // Clear wins over a coincident toggle for count/state; pulse is unaffected.
      count_d    = '0;
      overflow_d = 1'b0;
      timer_d    = '0;
      state_d    = StIdle;
    end else begin
      if (tog_det) begin
        if (count_q == CountMax) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          if (tog_det) begin
            state_d = StActive;
            timer_d = '0;
          end
        end
        StActive: begin
          if (tog_det) begin
            timer_d = '0;
          end else if (timer_q == TimerLast) begin
            // Timer holds here so it can never wrap.
            state_d = StStall;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StStall: begin
          if (tog_det) begin
            state_d = StActive;
            timer_d = '0;
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end

    active_d  = (state_d == StActive);
    timeout_d = (state_d == StStall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      pulse_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timer_q    <= '0;
      state_q    <= StIdle;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      pulse_q    <= pulse_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      active_q   <= active_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pulse    = pulse_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign active   = active_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Self-checking bench for toggle_decoder (CW=4, TIMEOUT=8). A cycle model of the
// link receiver pushes the expected outputs for each drive into a queue; they are
// popped and compared once the DUT has taken the clock edge.
module tb_toggle_decoder;

  localparam int unsigned CW      = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int          CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, k_in, clr;
  logic          pulse, overflow, active, timeout;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  toggle_decoder #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .k_in     (k_in),
    .clr      (clr),
    .pulse    (pulse),
    .count    (count),
    .overflow (overflow),
    .active   (active),
    .timeout  (timeout)
  );

  typedef struct {
    int p;
    int cnt;
    int ovf;
    int act;
    int tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulse_seen = 0;

  // Reference model state; st: 0 idle, 1 active, 2 stall.
  int m_s1, m_s2, m_s3, m_p, m_cnt, m_ovf, m_tmr, m_st;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int k, input int c, input int r);
    int e;
    if (r != 0) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_p = 0;
      m_cnt = 0; m_ovf = 0; m_tmr = 0; m_st = 0;
    end else begin
      e    = (m_s2 != m_s3) ? 1 : 0;
      m_p  = e;
      m_s3 = m_s2;
      m_s2 = m_s1;
      m_s1 = k;
      if (c != 0) begin
        m_cnt = 0; m_ovf = 0; m_tmr = 0; m_st = 0;
      end else begin
        if (e != 0) begin
          if (m_cnt == CMAX) m_ovf = 1;
          else m_cnt++;
        end
        if (e != 0) begin
          m_st  = 1;
          m_tmr = 0;
        end else if (m_st == 1) begin
          if (m_tmr == TIMEOUT - 1) m_st = 2;
          else m_tmr++;
        end
      end
    end
  endtask

  task automatic step(input logic k, input logic c, input logic r);
    exp_t e;
    k_in = k;
    clr  = c;
    rst  = r;
    model_edge(int'(k), int'(c), int'(r));
    e.p = m_p; e.cnt = m_cnt; e.ovf = m_ovf;
    e.act = (m_st == 1) ? 1 : 0;
    e.tmo = (m_st == 2) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("pulse",    int'(pulse),    e.p);
    check_eq("count",    int'(count),    e.cnt);
    check_eq("overflow", int'(overflow), e.ovf);
    check_eq("active",   int'(active),   e.act);
    check_eq("timeout",  int'(timeout),  e.tmo);
    if (pulse === 1'b1) pulse_seen++;
  endtask

  logic kl;
  int   p0, n, hit;

  initial begin
    m_s1 = 0; m_s2 = 0; m_s3 = 0; m_p = 0;
    m_cnt = 0; m_ovf = 0; m_tmr = 0; m_st = 0;
    rst = 1'b1; k_in = 1'b0; clr = 1'b0;
    #2;

    // 1: reset, all outputs zero
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_active", int'(active), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // 2: single toggle -> pulse exactly after the third edge
    kl = 1'b1;
    step(kl, 1'b0, 1'b0);
    check_eq("lat_e1", int'(pulse), 0);
    step(kl, 1'b0, 1'b0);
    check_eq("lat_e2", int'(pulse), 0);
    step(kl, 1'b0, 1'b0);
    check_eq("lat_e3", int'(pulse), 1);
    check_eq("lat_cnt", int'(count), 1);
    check_eq("lat_act", int'(active), 1);
    step(kl, 1'b0, 1'b0);
    check_eq("lat_e4", int'(pulse), 0);

    // 3: toggles on consecutive cycles do not merge
    step(kl, 1'b1, 1'b0);
    p0 = pulse_seen;
    for (int i = 0; i < 5; i++) begin
      kl = ~kl;
      step(kl, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(kl, 1'b0, 1'b0);
    check_eq("b2b_pulses", pulse_seen - p0, 5);
    check_eq("b2b_count", int'(count), 5);

    // 4: saturation and sticky overflow, then clr
    step(kl, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      kl = ~kl;
      step(kl, 1'b0, 1'b0);
      step(kl, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(kl, 1'b0, 1'b0);
    check_eq("sat_count", int'(count), 15);
    check_eq("sat_ovf", int'(overflow), 1);
    step(kl, 1'b1, 1'b0);
    check_eq("clr_count", int'(count), 0);
    check_eq("clr_ovf", int'(overflow), 0);
    check_eq("clr_active", int'(active), 0);

    // 5: stall detection exactly TIMEOUT edges after the pulse edge
    kl = ~kl;
    step(kl, 1'b0, 1'b0);
    step(kl, 1'b0, 1'b0);
    step(kl, 1'b0, 1'b0);
    check_eq("to_pulse", int'(pulse), 1);
    n = 0; hit = 0;
    while (hit == 0 && n < 20) begin
      step(kl, 1'b0, 1'b0);
      n++;
      if (timeout === 1'b1) hit = 1;
    end
    check_eq("to_edges", n, TIMEOUT);
    kl = ~kl;
    for (int i = 0; i < 3; i++) step(kl, 1'b0, 1'b0);
    check_eq("to_resume_act", int'(active), 1);
    check_eq("to_resume_tmo", int'(timeout), 0);

    // clr on the same edge as a pulse: pulse kept, count/state cleared
    kl = ~kl;
    step(kl, 1'b0, 1'b0);
    step(kl, 1'b0, 1'b0);
    step(kl, 1'b1, 1'b0);
    check_eq("clr_edge_pulse", int'(pulse), 1);
    check_eq("clr_edge_count", int'(count), 0);
    for (int i = 0; i < 3; i++) step(kl, 1'b0, 1'b0);
    check_eq("clr_no_spurious", int'(count), 0);

    // 6: reset one cycle after a toggle drops it
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    p0 = pulse_seen;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    check_eq("rst_drop_pulses", pulse_seen - p0, 0);
    check_eq("rst_drop_count", int'(count), 0);
    // k_in high after reset differs from the transmitter reset level: one toggle
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check_eq("post_rst_pulses", pulse_seen - p0, 1);
    check_eq("post_rst_count", int'(count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
